// File: rtl/pw_trigger_seq.sv
// pw_trigger_seq: multi-pulse trigger sequencer.
//
// On each accepted pattern match it plays out a train of up to pNUM_TRIGGERS
// pulses on O_trigger, each with its own pre-pulse delay and high width. The
// pulse count and all delay/width fields are shadowed when a sequence starts,
// so the register block may change them freely while a sequence runs.
//
// Ports:
//   trigger_clk       sole clock
//   reset_i           asynchronous active-high reset
//   I_trigger_enable  level enable; dropping it aborts a running sequence
//   I_match           single-cycle match pulse that starts a sequence
//   I_num_triggers    pulses per sequence (0 -> 1, clamped to pNUM_TRIGGERS)
//   I_trigger_delays  delay k in slice k (low cycles before pulse k)
//   I_trigger_widths  width k in slice k (high cycles, 0 treated as 1)
//   O_trigger         registered trigger output
//   O_busy            high while a sequence is in progress
//   O_trigger_index   index of the pulse currently pending or active
//   O_done            one-cycle pulse in the first idle cycle after completion
//   O_match_ignored   one-cycle pulse after a match dropped while busy
module pw_trigger_seq #(
    parameter int unsigned pNUM_TRIGGERS        = 8,
    parameter int unsigned pTRIGGER_DELAY_WIDTH = 20,
    parameter int unsigned pTRIGGER_WIDTH_WIDTH = 17,
    parameter int unsigned pIDX_WIDTH           = $clog2(pNUM_TRIGGERS + 1)
) (
    input  logic                                          trigger_clk,
    input  logic                                          reset_i,
    input  logic                                          I_trigger_enable,
    input  logic                                          I_match,
    input  logic [pIDX_WIDTH-1:0]                         I_num_triggers,
    input  logic [pNUM_TRIGGERS*pTRIGGER_DELAY_WIDTH-1:0] I_trigger_delays,
    input  logic [pNUM_TRIGGERS*pTRIGGER_WIDTH_WIDTH-1:0] I_trigger_widths,
    output logic                                          O_trigger,
    output logic                                          O_busy,
    output logic [pIDX_WIDTH-1:0]                         O_trigger_index,
    output logic                                          O_done,
    output logic                                          O_match_ignored
);

    localparam int unsigned DW    = pTRIGGER_DELAY_WIDTH;
    localparam int unsigned WW    = pTRIGGER_WIDTH_WIDTH;
    localparam int unsigned IW    = pIDX_WIDTH;
    localparam int unsigned SEL_W = (pNUM_TRIGGERS > 1) ? $clog2(pNUM_TRIGGERS) : 1;

    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(pNUM_TRIGGERS);
    localparam logic [IW-1:0] IDX_LAST = IW'(pNUM_TRIGGERS - 1);
    localparam logic [DW-1:0] DLY_ONE  = DW'(1);
    localparam logic [WW-1:0] WID_ONE  = WW'(1);

    typedef enum logic [1:0] {StIdle, StDelay, StPulse} state_t;

    state_t        state_q;
    logic          trigger_q;
    logic          busy_q;
    logic          done_q;
    logic          ignored_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] last_q;      // index of the final pulse of the running sequence
    logic [DW-1:0] dcnt_q;      // delay cycles remaining, including the current one
    logic [WW-1:0] wcnt_q;      // high cycles remaining, including the current one
    logic [DW-1:0] delay_sh_q [pNUM_TRIGGERS];
    logic [WW-1:0] width_sh_q [pNUM_TRIGGERS];

    logic [DW-1:0] delay_in [pNUM_TRIGGERS];
    logic [WW-1:0] width_in [pNUM_TRIGGERS];
    logic [IW-1:0] last_in;
    logic [IW-1:0] nxt_idx;
    logic [DW-1:0] nxt_delay;
    logic [WW-1:0] nxt_width;
    logic [WW-1:0] cur_width;

    function automatic logic [WW-1:0] width_eff(input logic [WW-1:0] w);
        return (w == '0) ? WID_ONE : w;
    endfunction

    always_comb begin
        for (int k = 0; k < int'(pNUM_TRIGGERS); k++) begin
            delay_in[k] = I_trigger_delays[k*DW +: DW];
            width_in[k] = I_trigger_widths[k*WW +: WW];
        end
    end

    // Effective pulse count n, stored as the last index n-1.
    always_comb begin
        if (I_num_triggers == '0) begin
            last_in = '0;
        end else if (I_num_triggers > IDX_MAX) begin
            last_in = IDX_LAST;
        end else begin
            last_in = I_num_triggers - IDX_ONE;
        end
    end

    always_comb begin
        nxt_idx   = idx_q + IDX_ONE;
        nxt_delay = delay_sh_q[nxt_idx[SEL_W-1:0]];
        nxt_width = width_eff(width_sh_q[nxt_idx[SEL_W-1:0]]);
        cur_width = width_eff(width_sh_q[idx_q[SEL_W-1:0]]);
    end

    always_ff @(posedge trigger_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            trigger_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ignored_q  <= 1'b0;
            idx_q      <= '0;
            last_q     <= '0;
            dcnt_q     <= '0;
            wcnt_q     <= '0;
            delay_sh_q <= '{default: '0};
            width_sh_q <= '{default: '0};
        end else begin
            done_q    <= 1'b0;
            ignored_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (I_match && I_trigger_enable) begin
                        delay_sh_q <= delay_in;
                        width_sh_q <= width_in;
                        last_q     <= last_in;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        if (delay_in[0] == '0) begin
                            state_q   <= StPulse;
                            trigger_q <= 1'b1;
                            wcnt_q    <= width_eff(width_in[0]);
                        end else begin
                            state_q <= StDelay;
                            dcnt_q  <= delay_in[0];
                        end
                    end
                end
                default: begin
                    if (I_match) begin
                        ignored_q <= 1'b1;
                    end
                    if (!I_trigger_enable) begin
                        // Abort: silent return to idle, no done pulse.
                        state_q   <= StIdle;
                        trigger_q <= 1'b0;
                        busy_q    <= 1'b0;
                        idx_q     <= '0;
                        dcnt_q    <= '0;
                        wcnt_q    <= '0;
                    end else if (state_q == StDelay) begin
                        if (dcnt_q == DLY_ONE) begin
                            state_q   <= StPulse;
                            trigger_q <= 1'b1;
                            dcnt_q    <= '0;
                            wcnt_q    <= cur_width;
                        end else begin
                            dcnt_q <= dcnt_q - DLY_ONE;
                        end
                    end else if (wcnt_q == WID_ONE) begin
                        // Last high cycle of the current pulse.
                        if (idx_q != last_q) begin
                            idx_q <= nxt_idx;
                            if (nxt_delay == '0) begin
                                // Back-to-back: stay high across the boundary.
                                wcnt_q <= nxt_width;
                            end else begin
                                state_q   <= StDelay;
                                trigger_q <= 1'b0;
                                wcnt_q    <= '0;
                                dcnt_q    <= nxt_delay;
                            end
                        end else begin
                            state_q   <= StIdle;
                            trigger_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            idx_q     <= '0;
                            wcnt_q    <= '0;
                        end
                    end else begin
                        wcnt_q <= wcnt_q - WID_ONE;
                    end
                end
            endcase
        end
    end

    assign O_trigger       = trigger_q;
    assign O_busy          = busy_q;
    assign O_trigger_index = idx_q;
    assign O_done          = done_q;
    assign O_match_ignored = ignored_q;

endmodule

// File: doc/pw_trigger_seq.md
Name: pw_trigger_seq

Overview:
- Parametrised multi-pulse successor to the single-pulse trigger generator.
- On each pattern-match event it emits a programmable train of up to pNUM_TRIGGERS pulses on the trigger output; each pulse has its own delay and width.
- Sits in the trigger_clk domain between the pattern matcher and the CW/MCX trigger pins.
- All configuration comes from register-block outputs; it is quasi-static and is shadowed at sequence start.

Parameters:
- pNUM_TRIGGERS, 8, maximum pulses per sequence (>=1).
- pTRIGGER_DELAY_WIDTH, 20, bits per delay field.
- pTRIGGER_WIDTH_WIDTH, 17, bits per width field.
- pIDX_WIDTH, $clog2(pNUM_TRIGGERS+1), width of pulse count/index fields.

Ports:
- trigger_clk  in  1  sole clock.
- reset_i  in  1  asynchronous, active-high reset.
- I_trigger_enable  in  1  level; sequences run only while high.
- I_match  in  1  single-cycle match pulse, synchronous to trigger_clk.
- I_num_triggers  in  pIDX_WIDTH  pulses per sequence.
- I_trigger_delays  in  pNUM_TRIGGERS*pTRIGGER_DELAY_WIDTH  delay k in slice k.
- I_trigger_widths  in  pNUM_TRIGGERS*pTRIGGER_WIDTH_WIDTH  width k in slice k.
- O_trigger  out  1  registered trigger output.
- O_busy  out  1  high while a sequence is in progress.
- O_trigger_index  out  pIDX_WIDTH  index of the pulse currently pending or active.
- O_done  out  1  one-cycle pulse on sequence completion.
- O_match_ignored  out  1  one-cycle pulse when a match is dropped.

Behaviour:
- Reset: all outputs 0 (O_trigger, O_busy, O_trigger_index, O_done, O_match_ignored); FSM=IDLE; counters and shadow registers cleared.
- FSM states: IDLE, DELAY, PULSE.
- IDLE -> DELAY on I_match & I_trigger_enable.
  - In that cycle, capture I_num_triggers and all delay/width slices into shadow registers.
  - Set index=0 and load the delay counter with delay[0].
- Effective count: n = (I_num_triggers==0) ? 1 : min(I_num_triggers, pNUM_TRIGGERS).
- Timing, first pulse: with the match at cycle 0, O_trigger first goes high at cycle delay[0]+1.
- Timing, pulse k>0: first high cycle is delay[k]+1 cycles after the last high cycle of pulse k-1, i.e. exactly delay[k] low cycles between pulses.
  - delay[k]=0 gives back-to-back pulses; O_trigger stays high continuously across the boundary.
- Width: each pulse is high for width[k] cycles; width 0 is treated as 1.
- DELAY: decrement the counter; when it reaches 0, go to PULSE next cycle with O_trigger=1.
- PULSE: count down the width.
  - After the last high cycle, if index<n-1: increment index and go to DELAY, or directly to PULSE if delay=0.
  - Otherwise go to IDLE.
- O_busy = 1 in DELAY and PULSE.
- O_done = 1 in the first IDLE cycle after a completed sequence. A match in that same cycle is accepted and starts a new sequence.
- Match while busy: dropped; O_match_ignored pulses in the cycle after the match. The running sequence is unaffected.
- Match while I_trigger_enable=0 in IDLE: dropped silently, no ignored pulse.
- Enable deasserted mid-sequence: abort.
  - Next cycle: O_trigger=0, O_busy=0, FSM=IDLE, index=0; O_done is not asserted.
- Config changes during a sequence have no effect until the next start.
- Counters are sized to their fields; no wrap is possible, since they only load and count down to 0.
- Reset mid-sequence: all outputs go to 0 immediately (asynchronous).

Test Plan:
- n=1, delay0=3, width0=2, match at cycle 0 -> O_trigger high cycles 4-5; O_done at cycle 6; O_busy high cycles 1-5.
- n=3, delays {0,2,1}, widths {1,3,2} -> O_trigger high at cycles 1, 4-6 and 8-9; O_trigger_index reads 0, 1, 2 in turn; O_done at cycle 10.
- n=2, delays {1,0}, widths {2,2} -> O_trigger high continuously for cycles 2-5; single O_done at cycle 6.
- Second match during DELAY of a running sequence -> O_match_ignored pulse the next cycle; pulse train identical to the no-second-match case. A match in the O_done cycle starts a new sequence.
- I_num_triggers=0 -> one pulse. I_num_triggers=15 with pNUM_TRIGGERS=8 -> exactly 8 pulses. Width 0 -> one-cycle pulse.
- Drop I_trigger_enable during pulse 1 -> O_trigger low the next cycle, no O_done, later match ignored until enable returns. Assert reset_i mid-PULSE -> outputs 0 with no clock edge.
